riscv_run_ctrl: RTL and testbench
=================================

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each observed processor output channel.
REQ-002 Parameter NCH, default 3: number of observed output channels.
REQ-003 Parameter RST_CYCLES, default 10: number of cycles the processor is held in reset after start.
REQ-004 Parameter RUN_CYCLES, default 50: maximum number of run cycles sampled.
REQ-005 Parameter STALL_LIMIT, default 16: number of consecutive unchanged samples that declares a stall.
REQ-006 clock  in  1  single clock; all logic updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-009 abort  in  1  in HOLD_RST or RUN, returns the block to IDLE.
REQ-010 dut_out  in  NCH*WIDTH  concatenated processor outputs; channel 0 occupies the LSBs.
REQ-011 exp_sig  in  WIDTH  expected signature; compared only in DONE.
REQ-012 dut_reset  out  1  reset driven to the processor.
REQ-013 running  out  1  high while in RUN.
REQ-014 done  out  1  high while in DONE.
REQ-015 pass  out  1  valid while done is high.
REQ-016 stall  out  1  run ended on the stall condition.
REQ-017 sig  out  WIDTH  accumulated output signature.
REQ-018 cycles  out  $clog2(RUN_CYCLES+1)  number of RUN samples taken.

Function
REQ-019 FSM states: IDLE, HOLD_RST, RUN, DONE.
REQ-020 IDLE: start=1 moves to HOLD_RST on the next cycle; all other inputs are ignored.
REQ-021 Entry to HOLD_RST clears sig, cycles, stall and the stall counter.
REQ-022 HOLD_RST lasts exactly RST_CYCLES cycles, then moves to RUN.
REQ-023 dut_reset is 1 in IDLE and HOLD_RST and 0 in RUN and DONE.
REQ-024 RUN samples dut_out every cycle: sig <= rotl1(sig) XOR (XOR-reduction of all NCH channels), and cycles increments by 1.
REQ-025 RUN moves to DONE on the cycle after the sample that brings cycles to RUN_CYCLES.
REQ-026 Stall counter: increments when a RUN sample equals the previous sample; clears otherwise; the first RUN sample never counts as a match.
REQ-027 When the stall counter reaches STALL_LIMIT, the block sets stall=1 and moves to DONE, even if cycles < RUN_CYCLES.
REQ-028 If the stall limit and the RUN_CYCLES limit are reached in the same cycle, stall=1 and the block moves to DONE.
REQ-029 DONE: pass = (sig == exp_sig) AND NOT stall, evaluated combinationally; sig, cycles and stall are held.
REQ-030 DONE with start=1 moves to HOLD_RST (re-run); without start, DONE is held indefinitely.
REQ-031 abort in HOLD_RST or RUN moves to IDLE next cycle and has priority over all other transitions; sig and cycles hold their last values.
REQ-032 start in HOLD_RST or RUN is ignored; abort in IDLE or DONE is ignored.
REQ-033 cycles saturates at RUN_CYCLES; it never wraps.

Reset
REQ-034 reset=1 forces state to IDLE on the next edge, regardless of current state, including mid-run.
REQ-035 Reset values: dut_reset=1, running=0, done=0, pass=0, stall=0, sig=0, cycles=0, stall counter=0.
REQ-036 reset has priority over start and abort.

Structure
REQ-037 The state enum and the signature rotate/fold helper function are defined in the shared package riscv_pkg.
REQ-038 The signature register is implemented as sub-module run_sig_misr, with ports clock, reset, clr, en, din[NCH*WIDTH] and sig[WIDTH].
REQ-039 The processor instance is not contained in this block; its outputs connect in by port only.

Verification (defaults unless stated)
REQ-040 start pulse at cycle 0 -> dut_reset high for cycles 1..10, running high for 50 cycles, then done=1 and cycles=50.
REQ-041 dut_out held at constant 0x1 on every channel -> stall=1 and done after 16 matching samples, cycles=17, pass=0.
REQ-042 dut_out channels = {k, 2k, 3k} at RUN sample k, exp_sig = reference-model value -> pass=1; same run with exp_sig bit 0 flipped -> pass=0.
REQ-043 abort asserted at RUN sample 20 -> IDLE next cycle, dut_reset=1, done=0, cycles=20 held.
REQ-044 reset asserted mid-RUN -> all outputs at their reset values next cycle; a subsequent start completes a clean 10+50-cycle run.
REQ-045 start asserted in DONE -> sig=0 and cycles=0 on the HOLD_RST entry cycle, with a full re-run identical to the first.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V run controller.
// Holds the run FSM encoding and the signature step function.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  // Widest signature the step helper supports.
  localparam int SIG_MAX_W = 64;

  // One signature step: rotate left by one within w bits, then
  // XOR in the folded sample. Bits above w must be zero on entry.
  function automatic logic [SIG_MAX_W-1:0] sig_step(
    input logic [SIG_MAX_W-1:0] s,
    input logic [SIG_MAX_W-1:0] f,
    input int                   w
  );
    logic [SIG_MAX_W-1:0] m;
    logic [SIG_MAX_W-1:0] r;
    m = {SIG_MAX_W{1'b1}} >> (SIG_MAX_W - w);
    r = ((s << 1) | (s >> (w - 1))) & m;
    return r ^ f;
  endfunction

endpackage

// File: rtl/run_sig_misr.sv
// Signature register for the run controller.
// Folds all channels per sample into a rotating XOR signature.
module run_sig_misr
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]     sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] fold;

  // XOR-reduce every channel of the sample.
  always_comb begin
    fold = '0;
    for (int c = 0; c < NCH; c++) begin
      fold = fold ^ din[c*WIDTH +: WIDTH];
    end
  end

  // Clear wins over sampling; otherwise hold.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = WIDTH'(sig_step(SIG_MAX_W'(sig_q),
                              SIG_MAX_W'(fold),
                              WIDTH));
    end
  end

  // Signature state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: holds the core in reset, samples its outputs,
// and reports signature, sample count, stall and pass/fail.
module riscv_run_ctrl
  import riscv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NCH         = 3,
  parameter int RST_CYCLES  = 10,
  parameter int RUN_CYCLES  = 50,
  parameter int STALL_LIMIT = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NCH*WIDTH-1:0]              dut_out,
  input  logic [WIDTH-1:0]                  exp_sig,
  output logic                              dut_reset,
  output logic                              running,
  output logic                              done,
  output logic                              pass,
  output logic                              stall,
  output logic [WIDTH-1:0]                  sig,
  output logic [$clog2(RUN_CYCLES+1)-1:0]   cycles
);

  localparam int CW = $clog2(RUN_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  run_state_e           state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]        cycles_q, cycles_d;
  logic                 stall_q, stall_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [NCH*WIDTH-1:0] prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic                 clr;
  logic                 en;
  logic                 match;

  // Next-state, counters and stall detection.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycles_d    = cycles_q;
    stall_d     = stall_q;
    scnt_d      = scnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    clr         = 1'b0;
    en          = 1'b0;
    match       = have_prev_q && (dut_out == prev_q);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HOLD;
          clr     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          en          = 1'b1;
          prev_d      = dut_out;
          have_prev_d = 1'b1;
          scnt_d      = match ? scnt_q + SW'(1) : '0;
          if (cycles_q != CW'(RUN_CYCLES)) begin
            cycles_d = cycles_q + CW'(1);
          end
          if (scnt_d == SW'(STALL_LIMIT)) begin
            stall_d = 1'b1;
            state_d = ST_DONE;
          end else if (cycles_d == CW'(RUN_CYCLES)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_HOLD;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      rst_cnt_d   = '0;
      cycles_d    = '0;
      stall_d     = 1'b0;
      scnt_d      = '0;
      have_prev_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cycles_q    <= '0;
      stall_q     <= 1'b0;
      scnt_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      stall_q     <= stall_d;
      scnt_q      <= scnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  run_sig_misr #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_misr (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .din   (dut_out),
    .sig   (sig)
  );

  assign dut_reset = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (sig == exp_sig) && !stall_q;
  assign stall     = stall_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl at default parameters.
// Table of full runs plus hand sequences for abort/reset.
module tb_riscv_run_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [95:0] dut_out;
  logic [31:0] exp_sig;
  logic        dut_reset;
  logic        running;
  logic        done;
  logic        pass;
  logic        stall;
  logic [31:0] sig;
  logic [5:0]  cycles;

  int n_cmp;
  int n_bad;

  typedef struct {
    int mode;
    bit flip;
    int n;
    bit stl;
    bit pas;
  } vec_t;

  vec_t tv [8];

  riscv_run_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .dut_out   (dut_out),
    .exp_sig   (exp_sig),
    .dut_reset (dut_reset),
    .running   (running),
    .done      (done),
    .pass      (pass),
    .stall     (stall),
    .sig       (sig),
    .cycles    (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] pat(input int k);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = k;
    b = a * 2;
    c = a * 3;
    return {c, b, a};
  endfunction

  function automatic logic [95:0] stim(input int mode, input int k);
    logic [31:0] a;
    a = k;
    case (mode)
      0: return pat(k);
      1: return {32'h1, 32'h1, 32'h1};
      2: return 96'h0;
      3: return {a, a, a};
      4: return (k % 2 == 1) ? {3{32'hA5A5A5A5}} : {3{32'h5A5A5A5A}};
      5: return (k <= 30) ? pat(k) : pat(30);
      6: return (k <= 34) ? pat(k) : pat(34);
      default: return 96'h0;
    endcase
  endfunction

  function automatic logic [31:0] model(input int mode, input int n);
    logic [31:0] s;
    logic [95:0] d;
    s = 32'h0;
    for (int k = 1; k <= n; k++) begin
      d = stim(mode, k);
      s = {s[30:0], s[31]} ^ d[31:0] ^ d[63:32] ^ d[95:64];
    end
    return s;
  endfunction

  task automatic hold_phase();
    for (int c = 1; c <= 10; c++) begin
      chk("hold_dut_reset", dut_reset, 1);
      chk("hold_running", running, 0);
      tick();
    end
  endtask

  task automatic run_vec(input int i);
    logic [31:0] s;
    s = model(tv[i].mode, tv[i].n);
    exp_sig = tv[i].flip ? (s ^ 32'h1) : s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("entry_sig", sig, 0);
    chk("entry_cycles", cycles, 0);
    chk("entry_stall", stall, 0);
    chk("entry_done", done, 0);
    hold_phase();
    for (int k = 1; k <= tv[i].n; k++) begin
      dut_out = stim(tv[i].mode, k);
      chk("run_running", running, 1);
      chk("run_dut_reset", dut_reset, 0);
      chk("run_cycles", cycles, k - 1);
      tick();
    end
    chk("end_done", done, 1);
    chk("end_running", running, 0);
    chk("end_cycles", cycles, tv[i].n);
    chk("end_stall", stall, tv[i].stl);
    chk("end_sig", sig, s);
    chk("end_pass", pass, tv[i].pas);
    dut_out = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("done_hold", done, 1);
    chk("done_sig_hold", sig, s);
    chk("done_cyc_hold", cycles, tv[i].n);
  endtask

  initial begin
    logic [31:0] s20;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    dut_out = '0;
    exp_sig = '0;

    tv[0] = '{0, 1'b0, 50, 1'b0, 1'b1};
    tv[1] = '{0, 1'b1, 50, 1'b0, 1'b0};
    tv[2] = '{1, 1'b0, 17, 1'b1, 1'b0};
    tv[3] = '{2, 1'b0, 17, 1'b1, 1'b0};
    tv[4] = '{3, 1'b0, 50, 1'b0, 1'b1};
    tv[5] = '{4, 1'b0, 50, 1'b0, 1'b1};
    tv[6] = '{5, 1'b0, 46, 1'b1, 1'b0};
    tv[7] = '{6, 1'b0, 50, 1'b1, 1'b0};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_stall", stall, 0);
    chk("rst_sig", sig, 0);
    chk("rst_cycles", cycles, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort", dut_reset, 1);

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end

    // abort after 20 samples; start during RUN must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    hold_phase();
    for (int k = 1; k <= 20; k++) begin
      dut_out = pat(k);
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    s20 = model(0, 20);
    chk("pre_abort_cycles", cycles, 20);
    dut_out = pat(21);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_sig = s20;
    chk("abort_running", running, 0);
    chk("abort_dut_reset", dut_reset, 1);
    chk("abort_done", done, 0);
    chk("abort_cycles", cycles, 20);
    chk("abort_sig", sig, s20);
    chk("abort_pass", pass, 0);
    abort = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    abort = 1'b0;
    chk("idle_stays", running, 0);
    chk("idle_cycles", cycles, 20);

    // abort during HOLD_RST
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("hold_abort_idle", running, 0);
      tick();
    end
    chk("hold_abort_cycles", cycles, 0);

    // reset mid-run with start and abort also high
    start = 1'b1;
    tick();
    start = 1'b0;
    hold_phase();
    for (int k = 1; k <= 15; k++) begin
      dut_out = pat(k);
      tick();
    end
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    chk("mrst_dut_reset", dut_reset, 1);
    chk("mrst_running", running, 0);
    chk("mrst_done", done, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_sig", sig, 0);
    chk("mrst_cycles", cycles, 0);
    tick();
    chk("mrst_idle", running, 0);
    run_vec(0);

    // reset from DONE after a stall run
    run_vec(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("drst_stall", stall, 0);
    chk("drst_done", done, 0);
    chk("drst_sig", sig, 0);
    chk("drst_cycles", cycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
